// File: rtl/linea_retardo.sv
// Sample delay line: Depth registered stages of Width bits, shifted on enable,
// flushed by a synchronous clear. count/valid track how many stages hold
// samples received since the last reset or clear.
module linea_retardo #(
   parameter  int unsigned Width = 23,
   parameter  int unsigned Depth = 4,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic                     clk44kHz,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [Width-1:0]         datoIn,
   output logic [Width-1:0]         datoOut,
   output logic [Depth*Width-1:0]   taps,
   output logic [CntW-1:0]          count,
   output logic                     valid
);

   localparam logic [CntW-1:0] CntFull = CntW'(Depth);

   logic [Width-1:0] stage_q [Depth];
   logic [Width-1:0] stage_d [Depth];
   logic [CntW-1:0]  count_q, count_d;
   logic             valid_q, valid_d;

   // Next state: clear wins over enable; with neither, everything holds.
   always_comb begin
      stage_d = stage_q;
      count_d = count_q;
      valid_d = valid_q;
      if (clear) begin
         for (int unsigned k = 0; k < Depth; k++) begin
            stage_d[k] = '0;
         end
         count_d = '0;
         valid_d = 1'b0;
      end else if (enable) begin
         stage_d[0] = datoIn;
         for (int unsigned k = 1; k < Depth; k++) begin
            stage_d[k] = stage_q[k-1];
         end
         // Saturate at Depth rather than wrapping.
         if (count_q != CntFull) begin
            count_d = count_q + CntW'(1);
         end
         valid_d = (count_d == CntFull);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk44kHz or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < Depth; k++) begin
            stage_q[k] <= '0;
         end
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         stage_q <= stage_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Outputs come straight from the registers; taps packs stage 0 in the LSBs.
   always_comb begin
      taps = '0;
      for (int unsigned k = 0; k < Depth; k++) begin
         taps[k*Width +: Width] = stage_q[k];
      end
   end

   assign datoOut = stage_q[Depth-1];
   assign count   = count_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_linea_retardo.sv
// Directed bench for linea_retardo at Width=23, Depth=4.
module tb_linea_retardo;

   localparam int unsigned W = 23;
   localparam int unsigned D = 4;
   localparam int unsigned NVec = 21;

   logic             clk44kHz;
   logic             reset;
   logic             enable;
   logic             clear;
   logic [W-1:0]     datoIn;
   logic [W-1:0]     datoOut;
   logic [D*W-1:0]   taps;
   logic [2:0]       count;
   logic             valid;

   int total;
   int bad;

   typedef struct {
      logic         en;
      logic         clr;
      logic [W-1:0] din;
      logic [W-1:0] t0;
      logic [W-1:0] t1;
      logic [W-1:0] t2;
      logic [W-1:0] t3;
      logic [2:0]   cnt;
      logic         vld;
   } vec_t;

   vec_t vecs [NVec];

   linea_retardo #(
      .Width (W),
      .Depth (D)
   ) dut (
      .clk44kHz (clk44kHz),
      .reset    (reset),
      .enable   (enable),
      .clear    (clear),
      .datoIn   (datoIn),
      .datoOut  (datoOut),
      .taps     (taps),
      .count    (count),
      .valid    (valid)
   );

   initial clk44kHz = 1'b0;
   always #5 clk44kHz = ~clk44kHz;

   task automatic chk(input string name, input logic [D*W-1:0] act, input logic [D*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] t0, input logic [W-1:0] t1,
                          input logic [W-1:0] t2, input logic [W-1:0] t3,
                          input logic [2:0] cnt, input logic vld);
      logic [D*W-1:0] exp_taps;
      exp_taps = {t3, t2, t1, t0};
      chk({tag, ".taps"},    taps,                exp_taps);
      chk({tag, ".datoOut"}, (D*W)'(datoOut),     (D*W)'(t3));
      chk({tag, ".count"},   (D*W)'(count),       (D*W)'(cnt));
      chk({tag, ".valid"},   (D*W)'(valid),       (D*W)'(vld));
   endtask

   task automatic step(input logic en, input logic clr, input logic [W-1:0] din);
      enable = en;
      clear  = clr;
      datoIn = din;
      @(posedge clk44kHz);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      // Fill, flush, fill with a gap, clear-beats-enable, saturation, hold, clear.
      vecs[0]  = '{1'b1, 1'b0, 23'd1,       23'd1,    23'd0,    23'd0,    23'd0,    3'd1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 23'd2,       23'd2,    23'd1,    23'd0,    23'd0,    3'd2, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 23'd3,       23'd3,    23'd2,    23'd1,    23'd0,    3'd3, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 23'd4,       23'd4,    23'd3,    23'd2,    23'd1,    3'd4, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 23'd0,       23'd0,    23'd0,    23'd0,    23'd0,    3'd0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 23'd1,       23'd1,    23'd0,    23'd0,    23'd0,    3'd1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 23'd2,       23'd2,    23'd1,    23'd0,    23'd0,    3'd2, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 23'd9,       23'd2,    23'd1,    23'd0,    23'd0,    3'd2, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 23'd9,       23'd2,    23'd1,    23'd0,    23'd0,    3'd2, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 23'd9,       23'd2,    23'd1,    23'd0,    23'd0,    3'd2, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 23'd3,       23'd3,    23'd2,    23'd1,    23'd0,    3'd3, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 23'd4,       23'd4,    23'd3,    23'd2,    23'd1,    3'd4, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 23'h7FFFFF,  23'd0,    23'd0,    23'd0,    23'd0,    3'd0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 23'h10,      23'h10,   23'd0,    23'd0,    23'd0,    3'd1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 23'h11,      23'h11,   23'h10,   23'd0,    23'd0,    3'd2, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 23'h12,      23'h12,   23'h11,   23'h10,   23'd0,    3'd3, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 23'h13,      23'h13,   23'h12,   23'h11,   23'h10,   3'd4, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 23'h14,      23'h14,   23'h13,   23'h12,   23'h11,   3'd4, 1'b1};
      vecs[18] = '{1'b1, 1'b0, 23'h15,      23'h15,   23'h14,   23'h13,   23'h12,   3'd4, 1'b1};
      vecs[19] = '{1'b0, 1'b0, 23'h7FFFFF,  23'h15,   23'h14,   23'h13,   23'h12,   3'd4, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 23'h7FFFFF,  23'd0,    23'd0,    23'd0,    23'd0,    3'd0, 1'b0};

      // Reset applied before any clock edge: outputs must clear asynchronously.
      reset  = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      datoIn = '0;
      #3;
      chk_all("rst_noclk", 23'd0, 23'd0, 23'd0, 23'd0, 3'd0, 1'b0);
      @(negedge clk44kHz);
      reset = 1'b1;

      for (int i = 0; i < int'(NVec); i++) begin
         step(vecs[i].en, vecs[i].clr, vecs[i].din);
         chk_all($sformatf("vec%0d", i), vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3,
                 vecs[i].cnt, vecs[i].vld);
      end

      // Asynchronous reset mid-fill, then refill from zero.
      step(1'b1, 1'b0, 23'h55);
      step(1'b1, 1'b0, 23'h66);
      chk_all("prefill", 23'h66, 23'h55, 23'd0, 23'd0, 3'd2, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      chk_all("async_rst", 23'd0, 23'd0, 23'd0, 23'd0, 3'd0, 1'b0);
      #2;
      reset = 1'b1;
      step(1'b1, 1'b0, 23'h21);
      chk_all("refill1", 23'h21, 23'd0, 23'd0, 23'd0, 3'd1, 1'b0);
      step(1'b1, 1'b0, 23'h22);
      chk_all("refill2", 23'h22, 23'h21, 23'd0, 23'd0, 3'd2, 1'b0);
      step(1'b1, 1'b0, 23'h23);
      chk_all("refill3", 23'h23, 23'h22, 23'h21, 23'd0, 3'd3, 1'b0);
      step(1'b1, 1'b0, 23'h24);
      chk_all("refill4", 23'h24, 23'h23, 23'h22, 23'h21, 3'd4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
